// File: rtl/cache_pkg.sv
// Shared types and constants for the I/D cache refill arbiter.
// Encodes arbiter states, requester identity and line geometry.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_e;

    localparam int LINE_BYTES = 64;
    localparam int WORD_BITS  = 32;

    // Clear the byte-offset bits so the captured address is always line aligned.
    function automatic logic [WORD_BITS-1:0] line_align(input logic [WORD_BITS-1:0] addr);
        return addr & ~WORD_BITS'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-way grant selector between the I-side and D-side refill requests.
// Round-robin favours the side that was not served last; fixed mode favours D.
module arb_pick
    import cache_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       req_i,
    input  logic       req_d,
    input  requester_e rr_last,
    output requester_e winner
);

    always_comb begin
        winner = REQ_I;
        if (req_i && req_d) begin
            if (RR_EN) begin
                winner = (rr_last == REQ_D) ? REQ_I : REQ_D;
            end else begin
                winner = REQ_D;
            end
        end else if (req_d) begin
            winner = REQ_D;
        end
    end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one MMU burst-read channel between the I-cache and D-cache refill engines.
// One burst in flight; beats are routed back only to the granted owner.
module cache_refill_arbiter
    import cache_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter bit RR_EN     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_read_req,
    input  logic [WORD_BITS-1:0] inst_addr_mmu,
    output logic                 inst_addr_ok,
    output logic [WORD_BITS-1:0] inst_read_data,
    output logic                 inst_mmu_valid,
    output logic                 inst_mmu_last,
    input  logic                 data_read_req,
    input  logic [WORD_BITS-1:0] data_addr_mmu,
    output logic                 data_addr_ok,
    output logic [WORD_BITS-1:0] data_read_data,
    output logic                 data_mmu_valid,
    output logic                 data_mmu_last,
    output logic                 mem_read_req,
    output logic [WORD_BITS-1:0] mem_addr,
    input  logic                 mem_addr_ok,
    input  logic [WORD_BITS-1:0] mem_read_data,
    input  logic                 mem_valid,
    input  logic                 mem_last,
    output logic                 burst_err
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_e           state_q, state_d;
    requester_e           owner_q, owner_d;
    requester_e           rr_last_q, rr_last_d;
    requester_e           winner;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [WORD_BITS-1:0] addr_q, addr_d;
    logic                 orphan_q, orphan_d;
    logic                 burst_err_q, burst_err_d;
    logic                 owner_req;
    logic                 fwd_i, fwd_d;

    arb_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .req_i  (inst_read_req),
        .req_d  (data_read_req),
        .rr_last(rr_last_q),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= REQ_I;
            rr_last_q   <= REQ_D;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            orphan_q    <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_q      <= addr_d;
            orphan_q    <= orphan_d;
            burst_err_q <= burst_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        beat_cnt_d   = beat_cnt_q;
        addr_d       = addr_q;
        orphan_d     = orphan_q;
        burst_err_d  = burst_err_q;
        mem_read_req = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        fwd_i        = 1'b0;
        fwd_d        = 1'b0;
        owner_req    = (owner_q == REQ_I) ? inst_read_req : data_read_req;

        case (state_q)
            IDLE: begin
                if (inst_read_req || data_read_req) begin
                    owner_d = winner;
                    addr_d  = line_align((winner == REQ_I) ? inst_addr_mmu : data_addr_mmu);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // Committed: the MMU keeps seeing the request even if the owner withdraws.
                mem_read_req = 1'b1;
                if (mem_addr_ok) begin
                    inst_addr_ok = owner_req && (owner_q == REQ_I);
                    data_addr_ok = owner_req && (owner_q == REQ_D);
                    orphan_d     = !owner_req;
                    beat_cnt_d   = '0;
                    state_d      = DATA;
                end
            end
            DATA: begin
                fwd_i = !orphan_q && (owner_q == REQ_I);
                fwd_d = !orphan_q && (owner_q == REQ_D);
                if (mem_valid) begin
                    if (beat_cnt_q != LAST_BEAT) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    // Flags both an early last and a missing last at the final beat.
                    if (mem_last != (beat_cnt_q == LAST_BEAT)) begin
                        burst_err_d = 1'b1;
                    end
                    if (mem_last) begin
                        rr_last_d = owner_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr       = (state_q == ADDR) ? addr_q : '0;
    assign inst_read_data = fwd_i ? mem_read_data : '0;
    assign inst_mmu_valid = fwd_i && mem_valid;
    assign inst_mmu_last  = fwd_i && mem_last;
    assign data_read_data = fwd_d ? mem_read_data : '0;
    assign data_mmu_valid = fwd_d && mem_valid;
    assign data_mmu_last  = fwd_d && mem_last;
    assign burst_err      = burst_err_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: instance 0 round-robin, instance 1 fixed priority.
// A bench-side MMU drives bursts; expected beats go through a scoreboard queue.
module tb_cache_refill_arbiter;

  localparam int W = 69;
  localparam bit SIDE_I = 1'b0;
  localparam bit SIDE_D = 1'b1;

  logic clk;
  logic rst;

  logic        inst_req       [2];
  logic [31:0] inst_addr      [2];
  logic        inst_addr_ok   [2];
  logic [31:0] inst_read_data [2];
  logic        inst_mmu_valid [2];
  logic        inst_mmu_last  [2];
  logic        data_req       [2];
  logic [31:0] data_addr      [2];
  logic        data_addr_ok   [2];
  logic [31:0] data_read_data [2];
  logic        data_mmu_valid [2];
  logic        data_mmu_last  [2];
  logic        mem_read_req   [2];
  logic [31:0] mem_addr       [2];
  logic        mem_addr_ok    [2];
  logic [31:0] mem_rdata      [2];
  logic        mem_valid      [2];
  logic        mem_last       [2];
  logic        burst_err      [2];

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  cache_refill_arbiter #(.BURST_LEN(16), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .inst_read_req(inst_req[0]), .inst_addr_mmu(inst_addr[0]), .inst_addr_ok(inst_addr_ok[0]),
    .inst_read_data(inst_read_data[0]), .inst_mmu_valid(inst_mmu_valid[0]), .inst_mmu_last(inst_mmu_last[0]),
    .data_read_req(data_req[0]), .data_addr_mmu(data_addr[0]), .data_addr_ok(data_addr_ok[0]),
    .data_read_data(data_read_data[0]), .data_mmu_valid(data_mmu_valid[0]), .data_mmu_last(data_mmu_last[0]),
    .mem_read_req(mem_read_req[0]), .mem_addr(mem_addr[0]), .mem_addr_ok(mem_addr_ok[0]),
    .mem_read_data(mem_rdata[0]), .mem_valid(mem_valid[0]), .mem_last(mem_last[0]),
    .burst_err(burst_err[0])
  );

  cache_refill_arbiter #(.BURST_LEN(16), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .inst_read_req(inst_req[1]), .inst_addr_mmu(inst_addr[1]), .inst_addr_ok(inst_addr_ok[1]),
    .inst_read_data(inst_read_data[1]), .inst_mmu_valid(inst_mmu_valid[1]), .inst_mmu_last(inst_mmu_last[1]),
    .data_read_req(data_req[1]), .data_addr_mmu(data_addr[1]), .data_addr_ok(data_addr_ok[1]),
    .data_read_data(data_read_data[1]), .data_mmu_valid(data_mmu_valid[1]), .data_mmu_last(data_mmu_last[1]),
    .mem_read_req(mem_read_req[1]), .mem_addr(mem_addr[1]), .mem_addr_ok(mem_addr_ok[1]),
    .mem_read_data(mem_rdata[1]), .mem_valid(mem_valid[1]), .mem_last(mem_last[1]),
    .burst_err(burst_err[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [103:0] outs_all(input int d);
    return {inst_addr_ok[d], inst_read_data[d], inst_mmu_valid[d], inst_mmu_last[d],
            data_addr_ok[d], data_read_data[d], data_mmu_valid[d], data_mmu_last[d],
            mem_read_req[d], mem_addr[d], burst_err[d]};
  endfunction

  function automatic logic [W-1:0] obs_beat(input int d);
    return {d[0], inst_mmu_valid[d], inst_mmu_last[d], data_mmu_valid[d], data_mmu_last[d],
            inst_read_data[d], data_read_data[d]};
  endfunction

  function automatic logic [W-1:0] exp_beat(input int d, input bit side, input bit last,
                                            input logic [31:0] data);
    return {d[0], side == SIDE_I, last && (side == SIDE_I), side == SIDE_D, last && (side == SIDE_D),
            (side == SIDE_I) ? data : 32'h0, (side == SIDE_D) ? data : 32'h0};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (inst_mmu_valid[d] || data_mmu_valid[d]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'({inst_mmu_valid[d], data_mmu_valid[d]}), 128'(2'b00));
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("beat", 128'(obs_beat(d)), 128'(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int d, input bit side, input logic [31:0] addr);
    if (side == SIDE_I) begin
      inst_req[d] = 1'b1; inst_addr[d] = addr;
    end else begin
      data_req[d] = 1'b1; data_addr[d] = addr;
    end
  endtask

  task automatic drop_req(input int d, input bit side);
    if (side == SIDE_I) inst_req[d] = 1'b0;
    else data_req[d] = 1'b0;
  endtask

  // Acts as the MMU for one burst: expects the grant one cycle after the call,
  // accepts the address, then returns beats base..base+last_at with last on last_at.
  task automatic serve(input int d, input bit side, input logic [31:0] addr, input bit orphan,
                       input int last_at, input logic [31:0] base, input int rst_at);
    int wait_n;
    wait_n = 0;
    @(negedge clk);
    while (!mem_read_req[d] && wait_n < 20) begin
      wait_n++;
      @(negedge clk);
    end
    chk("grant_latency", 128'(wait_n), 128'(1));
    if (!mem_read_req[d]) return;
    chk("mem_addr", 128'(mem_addr[d]), 128'(addr));
    @(posedge clk); #1;
    if (orphan) drop_req(d, side);
    @(negedge clk);
    chk("addr_hold", 128'({mem_read_req[d], mem_addr[d]}), 128'({1'b1, addr}));
    @(posedge clk); #1;
    mem_addr_ok[d] = 1'b1;
    @(negedge clk);
    chk("addr_ok", 128'({inst_addr_ok[d], data_addr_ok[d]}),
        128'(orphan ? 2'b00 : ((side == SIDE_I) ? 2'b10 : 2'b01)));
    @(posedge clk); #1;
    mem_addr_ok[d] = 1'b0;
    drop_req(d, side);
    for (int i = 0; i <= last_at; i++) begin
      repeat ($urandom_range(0, 1)) begin
        mem_valid[d] = 1'b0; mem_last[d] = 1'b0;
        @(posedge clk); #1;
      end
      mem_valid[d] = 1'b1;
      mem_rdata[d] = base + 32'(i);
      mem_last[d]  = (i == last_at);
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 chk("async_reset_outs", 128'(outs_all(d)), 128'(0));
        mem_valid[d] = 1'b0; mem_last[d] = 1'b0; mem_rdata[d] = '0;
        inst_req[d] = 1'b0; data_req[d] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (!orphan) exp_q.push_back(exp_beat(d, side, i == last_at, base + 32'(i)));
      @(posedge clk); #1;
    end
    mem_valid[d] = 1'b0; mem_last[d] = 1'b0; mem_rdata[d] = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      inst_req[d] = 1'b0; inst_addr[d] = '0; data_req[d] = 1'b0; data_addr[d] = '0;
      mem_addr_ok[d] = 1'b0; mem_rdata[d] = '0; mem_valid[d] = 1'b0; mem_last[d] = 1'b0;
    end
    #1 rst = 1'b1;
    #2;
    chk("reset_outs_rr", 128'(outs_all(0)), 128'(0));
    chk("reset_outs_fp", 128'(outs_all(1)), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin right after reset: I first, then D after one bubble.
    set_req(0, SIDE_I, 32'h0000_2000);
    set_req(0, SIDE_D, 32'h0000_3000);
    serve(0, SIDE_I, 32'h0000_2000, 1'b0, 15, 32'h0000_0100, -1);
    serve(0, SIDE_D, 32'h0000_3000, 1'b0, 15, 32'h0000_0200, -1);

    // I-only refill of line 0x1040 with beats 0..15.
    set_req(0, SIDE_I, 32'h0000_1040);
    serve(0, SIDE_I, 32'h0000_1040, 1'b0, 15, 32'h0000_0000, -1);
    @(negedge clk);
    chk("burst_err_clean", 128'(burst_err[0]), 128'(0));
    @(posedge clk); #1;

    // Last served was I, so D wins the tie, then I.
    set_req(0, SIDE_I, 32'h0000_4000);
    set_req(0, SIDE_D, 32'h0000_5000);
    serve(0, SIDE_D, 32'h0000_5000, 1'b0, 15, 32'h0000_0300, -1);
    serve(0, SIDE_I, 32'h0000_4000, 1'b0, 15, 32'h0000_0400, -1);

    // I withdraws during ADDR: burst is drained with nothing forwarded.
    set_req(0, SIDE_I, 32'h0000_6000);
    serve(0, SIDE_I, 32'h0000_6000, 1'b1, 15, 32'h0000_0500, -1);

    // Early last on beat 10, then a normal burst; the error stays set.
    set_req(0, SIDE_D, 32'h0000_7000);
    serve(0, SIDE_D, 32'h0000_7000, 1'b0, 10, 32'h0000_0600, -1);
    @(negedge clk);
    chk("burst_err_early_last", 128'(burst_err[0]), 128'(1));
    @(posedge clk); #1;
    set_req(0, SIDE_I, 32'h0000_8000);
    serve(0, SIDE_I, 32'h0000_8000, 1'b0, 15, 32'h0000_0700, -1);
    @(negedge clk);
    chk("burst_err_sticky", 128'(burst_err[0]), 128'(1));
    @(posedge clk); #1;

    // Fixed priority: D wins every tie, I waits until D is idle.
    set_req(1, SIDE_I, 32'h0000_9000);
    set_req(1, SIDE_D, 32'h0000_A000);
    serve(1, SIDE_D, 32'h0000_A000, 1'b0, 15, 32'h0000_0800, -1);
    set_req(1, SIDE_D, 32'h0000_B000);
    serve(1, SIDE_D, 32'h0000_B000, 1'b0, 15, 32'h0000_0900, -1);
    serve(1, SIDE_I, 32'h0000_9000, 1'b0, 15, 32'h0000_0A00, -1);
    @(negedge clk);
    chk("burst_err_fp_clean", 128'(burst_err[1]), 128'(0));
    @(posedge clk); #1;

    // Valid without last at the final beat count: 17 beats, last on the 17th.
    set_req(1, SIDE_I, 32'h0000_C000);
    serve(1, SIDE_I, 32'h0000_C000, 1'b0, 16, 32'h0000_0B00, -1);
    @(negedge clk);
    chk("burst_err_overrun", 128'(burst_err[1]), 128'(1));
    @(posedge clk); #1;

    // Reset during beat 5 of a D burst, then a fresh I request.
    set_req(0, SIDE_D, 32'h0000_D000);
    serve(0, SIDE_D, 32'h0000_D000, 1'b0, 15, 32'h0000_0C00, 5);
    set_req(0, SIDE_I, 32'h0000_E040);
    serve(0, SIDE_I, 32'h0000_E040, 1'b0, 15, 32'h0000_0D00, -1);
    @(negedge clk);
    chk("burst_err_after_reset", 128'(burst_err[0]), 128'(0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
